// File: rtl/mem_access_unit.sv
// M-stage data-memory access: RV32I load/store formatting over a request/ready port with fault detection.
// Latency: 2 stall cycles for a zero-wait access, plus 1 per wait cycle, and 1 for a faulty access. stall_o holds the pipeline while an access is in flight.
module mem_access_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDRESS_WIDTH-1:0] alu_resultM_i,
  input  logic [DATA_WIDTH-1:0]    write_dataM_i,
  input  logic                     mem_writeM_i,
  input  logic [1:0]               result_srcM_i,
  input  logic [2:0]               funct3M_i,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0]    dmem_wdata_o,
  output logic [3:0]               dmem_be_o,
  input  logic                     dmem_ready_i,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata_i,
  output logic [DATA_WIDTH-1:0]    read_dataM_o,
  output logic                     stall_o,
  output logic                     fault_o,
  output logic [1:0]               fault_cause_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]               be_q, be_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [2:0]               f3_q, f3_d;
  logic [1:0]               lane_q, lane_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     flt_q, flt_d;
  logic [1:0]               cause_q, cause_d;

  logic                  is_store, access, illegal, misaligned;
  logic [3:0]            be_fmt;
  logic [DATA_WIDTH-1:0] wdata_fmt, rd_shift, load_fmt;

  // Access decode from the M-stage inputs; a store wins if both store and load are flagged.
  always_comb begin
    is_store = mem_writeM_i;
    access   = mem_writeM_i | (result_srcM_i == 2'b01);
    if (is_store) illegal = funct3M_i[2] | (funct3M_i[1:0] == 2'b11);
    else          illegal = (funct3M_i[1:0] == 2'b11) | (funct3M_i == 3'b110);
    misaligned = ((funct3M_i[1:0] == 2'b01) & alu_resultM_i[0]) |
                 ((funct3M_i[1:0] == 2'b10) & (alu_resultM_i[1:0] != 2'b00));
    be_fmt    = 4'b1111;
    wdata_fmt = write_dataM_i;
    case (funct3M_i[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << alu_resultM_i[1:0];
        wdata_fmt = {4{write_dataM_i[7:0]}};
      end
      2'b01: begin
        be_fmt    = alu_resultM_i[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{write_dataM_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension use the funct3/offset captured in IDLE, not the live inputs.
  always_comb begin
    rd_shift = dmem_rdata_i >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_fmt = {24'd0, rd_shift[7:0]};
      3'b101:  load_fmt = {16'd0, rd_shift[15:0]};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    flt_d   = flt_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          f3_d    = funct3M_i;
          lane_d  = alu_resultM_i[1:0];
          rdata_d = '0;
          flt_d   = 1'b0;
          if (illegal) begin
            flt_d   = 1'b1;
            cause_d = 2'b10;
            state_d = DONE;
          end else if (misaligned) begin
            flt_d   = 1'b1;
            cause_d = 2'b01;
            state_d = DONE;
          end else begin
            addr_d  = {alu_resultM_i[ADDRESS_WIDTH-1:2], 2'b00};
            be_d    = be_fmt;
            wdata_d = wdata_fmt;
            we_d    = is_store;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_ready_i) begin
          rdata_d = we_q ? '0 : load_fmt;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          flt_d   = 1'b1;
          cause_d = 2'b11;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      rdata_q <= '0;
      flt_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      flt_q   <= flt_d;
      cause_q <= cause_d;
    end
  end

  // Stall is forced low while reset is asserted so that the pipeline is released at once.
  assign stall_o       = rst_ni & (((state_q == IDLE) & access) | (state_q == REQ));
  assign dmem_req_o    = (state_q == REQ);
  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_wdata_o  = wdata_q;
  assign dmem_be_o     = be_q;
  assign read_dataM_o  = (state_q == DONE) ? rdata_q : '0;
  assign fault_o       = (state_q == DONE) & flt_q;
  assign fault_cause_o = cause_q;

endmodule
